// File: rtl/alu_simd_multiprecision_seq.sv
// Multi-limb sequencer for a combinational 4-operand SIMD ALU: ripples one Width-bit
// limb per cycle (LSB first), chaining the 2-bit limb carry, and returns sum + final carry.
module alu_simd_multiprecision_seq #(
  parameter int Width = 8,
  parameter int LIMBS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LIMBS*Width-1:0]   in_W,
  input  logic [LIMBS*Width-1:0]   in_X,
  input  logic [LIMBS*Width-1:0]   in_Y,
  input  logic [LIMBS*Width-1:0]   in_Z,
  input  logic [1:0]               in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LIMBS*Width-1:0]   out_S,
  output logic [1:0]               out_carry,
  output logic [Width-1:0]         alu_W,
  output logic [Width-1:0]         alu_X,
  output logic [Width-1:0]         alu_Y,
  output logic [Width-1:0]         alu_Z,
  output logic [1:0]               alu_op,
  output logic                     alu_Z_controller,
  output logic                     alu_S_controller,
  output logic                     alu_W_X_Y_controller,
  output logic [1:0]               alu_CIN_W_X_Y_CIN,
  output logic                     alu_CIN_Z_W_X_Y_CIN,
  output logic [1:0]               alu_result_SIMD_carry_in,
  input  logic [Width-1:0]         alu_S,
  input  logic [1:0]               alu_COUT_W_X_Y_CIN,
  input  logic                     alu_COUT_Z_W_X_Y_CIN
);

  localparam int KW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam int OPW = LIMBS * Width;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [1:0]       carry_reg;
  logic [OPW-1:0]   w_reg, x_reg, y_reg, z_reg;
  logic [OPW-1:0]   s_reg;
  logic [1:0]       cout_reg;
  logic [1:0]       limb_carry;
  logic             run;

  assign run        = (state == RUN);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_S      = s_reg;
  assign out_carry  = cout_reg;

  // Width rule guarantees the two carry parts never sum past 3.
  assign limb_carry = alu_COUT_W_X_Y_CIN + {1'b0, alu_COUT_Z_W_X_Y_CIN};

  // Mode controls are static; limb operands and carry-in are zero outside RUN.
  assign alu_op                   = 2'b00;
  assign alu_Z_controller         = 1'b0;
  assign alu_S_controller         = 1'b0;
  assign alu_W_X_Y_controller     = 1'b0;
  assign alu_CIN_Z_W_X_Y_CIN      = 1'b0;
  assign alu_result_SIMD_carry_in = 2'b00;
  assign alu_W             = run ? w_reg[k*Width +: Width] : '0;
  assign alu_X             = run ? x_reg[k*Width +: Width] : '0;
  assign alu_Y             = run ? y_reg[k*Width +: Width] : '0;
  assign alu_Z             = run ? z_reg[k*Width +: Width] : '0;
  assign alu_CIN_W_X_Y_CIN = run ? carry_reg : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      carry_reg <= 2'b00;
      w_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      s_reg     <= '0;
      cout_reg  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w_reg     <= in_W;
            x_reg     <= in_X;
            y_reg     <= in_Y;
            z_reg     <= in_Z;
            carry_reg <= in_cin;
            k         <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          s_reg[k*Width +: Width] <= alu_S;
          carry_reg               <= limb_carry;
          if (k == KW'(LIMBS - 1)) begin
            cout_reg <= limb_carry;
            k        <= '0;
            state    <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_simd_multiprecision_seq.sv
// Directed and randomized bench for alu_simd_multiprecision_seq with a behavioural
// combinational ALU model (S = W+X+Y+Z+CIN, carry split into two parts).
module tb_alu_simd_multiprecision_seq;
  localparam int W = 8;
  localparam int L = 4;
  localparam int N = W * L;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_W = '0, in_X = '0, in_Y = '0, in_Z = '0;
  logic [1:0]   in_cin = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_S;
  logic [1:0]   out_carry;
  logic [W-1:0] alu_W, alu_X, alu_Y, alu_Z, alu_S;
  logic [1:0]   alu_op, alu_CIN_W_X_Y_CIN, alu_result_SIMD_carry_in, alu_COUT_W_X_Y_CIN;
  logic         alu_Z_controller, alu_S_controller, alu_W_X_Y_controller;
  logic         alu_CIN_Z_W_X_Y_CIN, alu_COUT_Z_W_X_Y_CIN;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_simd_multiprecision_seq #(.Width(W), .LIMBS(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_W(in_W), .in_X(in_X), .in_Y(in_Y), .in_Z(in_Z), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_S(out_S), .out_carry(out_carry),
    .alu_W(alu_W), .alu_X(alu_X), .alu_Y(alu_Y), .alu_Z(alu_Z),
    .alu_op(alu_op), .alu_Z_controller(alu_Z_controller),
    .alu_S_controller(alu_S_controller), .alu_W_X_Y_controller(alu_W_X_Y_controller),
    .alu_CIN_W_X_Y_CIN(alu_CIN_W_X_Y_CIN), .alu_CIN_Z_W_X_Y_CIN(alu_CIN_Z_W_X_Y_CIN),
    .alu_result_SIMD_carry_in(alu_result_SIMD_carry_in),
    .alu_S(alu_S), .alu_COUT_W_X_Y_CIN(alu_COUT_W_X_Y_CIN),
    .alu_COUT_Z_W_X_Y_CIN(alu_COUT_Z_W_X_Y_CIN)
  );

  // ALU model: part A is the carry of W+X+Y+CIN, part B the carry of adding Z.
  logic [W+1:0] sum_a;
  logic [W:0]   sum_b;
  always_comb begin
    sum_a = {2'b00, alu_W} + {2'b00, alu_X} + {2'b00, alu_Y} + {{W{1'b0}}, alu_CIN_W_X_Y_CIN};
    sum_b = {1'b0, sum_a[W-1:0]} + {1'b0, alu_Z};
    alu_S = sum_b[W-1:0];
    alu_COUT_W_X_Y_CIN = sum_a[W+1:W];
    alu_COUT_Z_W_X_Y_CIN = sum_b[W];
  end

  // Issue one request and count edges from the handshake until out_valid.
  task automatic do_request(input logic [N-1:0] w, x, y, z, input logic [1:0] c,
                            output int edges, output bit timeout);
    int b;
    timeout = 1'b0;
    edges = 0;
    @(negedge clk);
    in_W = w; in_X = x; in_Y = y; in_Z = z; in_cin = c; in_valid = 1'b1;
    b = 0;
    while (!in_ready && b < 20) begin @(negedge clk); b++; end
    if (!in_ready) begin timeout = 1'b1; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_W = $urandom; in_X = $urandom; in_Y = $urandom; in_Z = $urandom; in_cin = 2'(3);
    while (edges < 50) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) break;
    end
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_carry, out_S} !== {1'b0, 1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b carry=%0d S=%h required 0 1 0 00000000",
               out_valid, in_ready, out_carry, out_S);
    end
    n_checks++;
    if ({alu_W, alu_X, alu_Y, alu_Z, alu_CIN_W_X_Y_CIN} !== '0) begin
      n_fail++;
      $display("FAIL reset_alu_inputs: W=%h X=%h Y=%h Z=%h cin=%0d required all 0",
               alu_W, alu_X, alu_Y, alu_Z, alu_CIN_W_X_Y_CIN);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_small();
    int e; bit to;
    do_request(32'd1, 32'd2, 32'd3, 32'd4, 2'd0, e, to);
    n_checks++;
    if (to || e != L) begin
      n_fail++;
      $display("FAIL small_latency: edges=%0d timeout=%b required %0d", e, to, L);
    end
    n_checks++;
    if ({out_carry, out_S} !== {2'd0, 32'h0000000A}) begin
      n_fail++;
      $display("FAIL small_sum: got %0d/%h required 0/0000000a", out_carry, out_S);
    end
    n_checks++;
    if ({alu_W, alu_CIN_W_X_Y_CIN, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL done_alu_idle: alu_W=%h cin=%0d in_ready=%b required 0 0 0",
               alu_W, alu_CIN_W_X_Y_CIN, in_ready);
    end
    release_result();
    $display("small: S=%h carry=%0d edges=%0d", out_S, out_carry, e);
  endtask

  task automatic test_ripple();
    int e; bit to;
    do_request(32'h000000FF, 32'h00000001, 32'h0, 32'h0, 2'd0, e, to);
    n_checks++;
    if (to || {out_carry, out_S} !== {2'd0, 32'h00000100}) begin
      n_fail++;
      $display("FAIL ripple: got %0d/%h timeout=%b required 0/00000100", out_carry, out_S, to);
    end
    release_result();
    $display("ripple: S=%h carry=%0d", out_S, out_carry);
  endtask

  task automatic test_all_ones();
    int e; bit to;
    do_request('1, '1, '1, '1, 2'd0, e, to);
    n_checks++;
    if (to || {out_carry, out_S} !== {2'd3, 32'hFFFFFFFC}) begin
      n_fail++;
      $display("FAIL ones_cin0: got %0d/%h required 3/fffffffc", out_carry, out_S);
    end
    release_result();
    do_request('1, '1, '1, '1, 2'd3, e, to);
    n_checks++;
    if (to || {out_carry, out_S} !== {2'd3, 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL ones_cin3: got %0d/%h required 3/ffffffff", out_carry, out_S);
    end
    release_result();
    $display("all_ones: S=%h carry=%0d", out_S, out_carry);
  endtask

  task automatic test_backpressure();
    int e; bit to;
    do_request(32'h11223344, 32'h01010101, 32'h0, 32'h0, 2'd1, e, to);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (to || {out_valid, in_ready, out_carry, out_S} !== {1'b1, 1'b0, 2'd0, 32'h12233446}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b %0d/%h required 1 0 0/12233446",
                 i, out_valid, in_ready, out_carry, out_S);
      end
    end
    release_result();
    n_checks++;
    if ({out_valid, in_ready, out_S} !== {1'b0, 1'b1, 32'h12233446}) begin
      n_fail++;
      $display("FAIL after_release: valid=%b ready=%b S=%h required 0 1 12233446",
               out_valid, in_ready, out_S);
    end
    $display("backpressure: S=%h held 5 cycles", out_S);
  endtask

  task automatic test_mid_reset();
    int e; bit to;
    @(negedge clk);
    in_W = 32'hAAAAAAAA; in_X = 32'h1; in_Y = '0; in_Z = '0; in_cin = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_S} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b ready=%b S=%h required 0 1 00000000",
               out_valid, in_ready, out_S);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset_idle: valid=%b ready=%b required 0 1", out_valid, in_ready);
      end
    end
    do_request(32'h12345678, '0, '0, '0, 2'd0, e, to);
    n_checks++;
    if (to || {out_carry, out_S} !== {2'd0, 32'h12345678}) begin
      n_fail++;
      $display("FAIL after_reset_req: got %0d/%h required 0/12345678", out_carry, out_S);
    end
    release_result();
    $display("mid_reset: next S=%h", out_S);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w, x, y, z;
    logic [1:0]   c;
    logic [N+1:0] exp_sum;
    int b;
    bit done;
    int start_fail;
    start_fail = n_fail;
    for (int i = 0; i < 10000; i++) begin
      w = $urandom; x = $urandom; y = $urandom; z = $urandom; c = 2'($urandom_range(3));
      exp_sum = {2'b00, w} + {2'b00, x} + {2'b00, y} + {2'b00, z} + {{N{1'b0}}, c};
      @(negedge clk);
      in_W = w; in_X = x; in_Y = y; in_Z = z; in_cin = c; in_valid = 1'b1;
      b = 0;
      while (!in_ready && b < 20) begin @(negedge clk); b++; end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_accept_timeout: req %0d in_ready=0 required 1", i);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      done = 1'b0;
      b = 0;
      while (!done && b < 50) begin
        @(negedge clk);
        out_ready = ($urandom_range(3) != 0);
        if (out_valid && out_ready) begin
          n_checks++;
          if ({out_carry, out_S} !== exp_sum) begin
            n_fail++;
            $display("FAIL b2b_sum: req %0d got %h required %h", i, {out_carry, out_S}, exp_sum);
          end
          done = 1'b1;
          @(posedge clk); #1;
        end
        b++;
      end
      out_ready = 1'b0;
      if (!done) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_result_timeout: req %0d no result", i);
        break;
      end
    end
    $display("back_to_back: 10000 requests, %0d failures", n_fail - start_fail);
  endtask

  initial begin
    test_reset();
    test_small();
    test_ripple();
    test_all_ones();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
